// File: rtl/framebuffer_avn_arbiter.sv
// Two-requester Avalon-MM arbiter for the sys_clk SRAM framebuffer port, with in-order read tags.
// Define FB_ARB_RR_EN for round-robin on contention; the default build uses fixed priority (requester 0).
module framebuffer_avn_arbiter #(
    parameter int AVN_AW   = 19,
    parameter int AVN_DW   = 16,
    parameter int RD_OUTST = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  s0_avn_read,
    input  logic                  s0_avn_write,
    input  logic [AVN_AW-1:0]     s0_avn_address,
    input  logic [AVN_DW/8-1:0]   s0_avn_byteenable,
    input  logic [AVN_DW-1:0]     s0_avn_writedata,
    output logic                  s0_avn_waitrequest,
    output logic [AVN_DW-1:0]     s0_avn_readdata,
    output logic                  s0_avn_readdatavalid,

    input  logic                  s1_avn_read,
    input  logic                  s1_avn_write,
    input  logic [AVN_AW-1:0]     s1_avn_address,
    input  logic [AVN_DW/8-1:0]   s1_avn_byteenable,
    input  logic [AVN_DW-1:0]     s1_avn_writedata,
    output logic                  s1_avn_waitrequest,
    output logic [AVN_DW-1:0]     s1_avn_readdata,
    output logic                  s1_avn_readdatavalid,

    output logic                  m_avn_read,
    output logic                  m_avn_write,
    output logic [AVN_AW-1:0]     m_avn_address,
    output logic [AVN_DW/8-1:0]   m_avn_byteenable,
    output logic [AVN_DW-1:0]     m_avn_writedata,
    input  logic                  m_avn_waitrequest,
    input  logic [AVN_DW-1:0]     m_avn_readdata,
    input  logic                  m_avn_readdatavalid
);

    localparam int TAG_AW = $clog2(RD_OUTST);
    localparam logic [TAG_AW:0] FULL_CNT = RD_OUTST[TAG_AW:0];

    logic req0, req1;
    logic gnt;
    logic lock, lock_gnt;
    logic sel_rd, sel_wr;
    logic cmd_vld, accept, push, pop, rd_block;
    logic fifo_full, fifo_empty, head_id;

    logic              tag_mem [RD_OUTST];
    logic [TAG_AW-1:0] wr_ptr, rd_ptr;
    logic [TAG_AW:0]   count;

    assign req0 = s0_avn_read | s0_avn_write;
    assign req1 = s1_avn_read | s1_avn_write;

`ifdef FB_ARB_RR_EN
    logic last_gnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            last_gnt <= 1'b1;
        else if (accept)
            last_gnt <= gnt;
    end

    always_comb begin
        gnt = 1'b0;
        if (lock)
            gnt = lock_gnt;
        else if (req0 & req1)
            gnt = ~last_gnt;
        else
            gnt = req1;
    end
`else
    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        gnt = 1'b0;
        if (lock)
            gnt = lock_gnt;
        else
            gnt = req1 & ~req0;
    end
`endif

    assign sel_rd           = gnt ? s1_avn_read       : s0_avn_read;
    assign sel_wr           = gnt ? s1_avn_write      : s0_avn_write;
    assign m_avn_address    = gnt ? s1_avn_address    : s0_avn_address;
    assign m_avn_byteenable = gnt ? s1_avn_byteenable : s0_avn_byteenable;
    assign m_avn_writedata  = gnt ? s1_avn_writedata  : s0_avn_writedata;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign pop        = m_avn_readdatavalid & ~fifo_empty;
    // A pop in the same cycle frees the slot the blocked read would need.
    assign rd_block   = sel_rd & fifo_full & ~pop;

    assign m_avn_read  = ~sys_rst & sel_rd & ~rd_block;
    assign m_avn_write = ~sys_rst & sel_wr;
    assign cmd_vld     = m_avn_read | m_avn_write;
    assign accept      = cmd_vld & ~m_avn_waitrequest;
    assign push        = m_avn_read & ~m_avn_waitrequest;

    assign s0_avn_waitrequest = sys_rst | gnt  | m_avn_waitrequest | rd_block;
    assign s1_avn_waitrequest = sys_rst | ~gnt | m_avn_waitrequest | rd_block;

    assign head_id              = tag_mem[rd_ptr];
    assign s0_avn_readdata      = m_avn_readdata;
    assign s1_avn_readdata      = m_avn_readdata;
    assign s0_avn_readdatavalid = ~sys_rst & pop & ~head_id;
    assign s1_avn_readdatavalid = ~sys_rst & pop & head_id;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lock     <= 1'b0;
            lock_gnt <= 1'b0;
        end else begin
            lock <= cmd_vld & m_avn_waitrequest;
            if (cmd_vld)
                lock_gnt <= gnt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                count <= count + 1'b1;
            else if (pop & ~push)
                count <= count - 1'b1;
        end
    end

    // NOTE: tag storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge sys_clk) begin
        if (push)
            tag_mem[wr_ptr] <= gnt;
    end

    a_s0_rw_excl: assert property (@(posedge sys_clk) disable iff (sys_rst)
        !(s0_avn_read && s0_avn_write))
        else $error("s0 read and write asserted together");

    a_s1_rw_excl: assert property (@(posedge sys_clk) disable iff (sys_rst)
        !(s1_avn_read && s1_avn_write))
        else $error("s1 read and write asserted together");

    a_rdv_no_tag: assert property (@(posedge sys_clk) disable iff (sys_rst)
        m_avn_readdatavalid |-> !fifo_empty)
        else $warning("readdatavalid with no read outstanding, response dropped");

endmodule

// File: tb/tb_framebuffer_avn_arbiter.sv
// Randomized and directed bench for framebuffer_avn_arbiter against a transaction-level reference model.
module tb_framebuffer_avn_arbiter;

    localparam int AW       = 19;
    localparam int DW       = 16;
    localparam int BW       = DW / 8;
    localparam int RD_OUTST = 4;
`ifdef FB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
    } cmd_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          s0_avn_read, s0_avn_write, s1_avn_read, s1_avn_write;
    logic [AW-1:0] s0_avn_address, s1_avn_address, m_avn_address;
    logic [BW-1:0] s0_avn_byteenable, s1_avn_byteenable, m_avn_byteenable;
    logic [DW-1:0] s0_avn_writedata, s1_avn_writedata, m_avn_writedata;
    logic          s0_avn_waitrequest, s1_avn_waitrequest;
    logic [DW-1:0] s0_avn_readdata, s1_avn_readdata, m_avn_readdata;
    logic          s0_avn_readdatavalid, s1_avn_readdatavalid;
    logic          m_avn_read, m_avn_write, m_avn_waitrequest, m_avn_readdatavalid;

    framebuffer_avn_arbiter #(.AVN_AW(AW), .AVN_DW(DW), .RD_OUTST(RD_OUTST)) dut (
        .sys_clk              (sys_clk),
        .sys_rst              (sys_rst),
        .s0_avn_read          (s0_avn_read),
        .s0_avn_write         (s0_avn_write),
        .s0_avn_address       (s0_avn_address),
        .s0_avn_byteenable    (s0_avn_byteenable),
        .s0_avn_writedata     (s0_avn_writedata),
        .s0_avn_waitrequest   (s0_avn_waitrequest),
        .s0_avn_readdata      (s0_avn_readdata),
        .s0_avn_readdatavalid (s0_avn_readdatavalid),
        .s1_avn_read          (s1_avn_read),
        .s1_avn_write         (s1_avn_write),
        .s1_avn_address       (s1_avn_address),
        .s1_avn_byteenable    (s1_avn_byteenable),
        .s1_avn_writedata     (s1_avn_writedata),
        .s1_avn_waitrequest   (s1_avn_waitrequest),
        .s1_avn_readdata      (s1_avn_readdata),
        .s1_avn_readdatavalid (s1_avn_readdatavalid),
        .m_avn_read           (m_avn_read),
        .m_avn_write          (m_avn_write),
        .m_avn_address        (m_avn_address),
        .m_avn_byteenable     (m_avn_byteenable),
        .m_avn_writedata      (m_avn_writedata),
        .m_avn_waitrequest    (m_avn_waitrequest),
        .m_avn_readdata       (m_avn_readdata),
        .m_avn_readdatavalid  (m_avn_readdatavalid)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: pending commands per requester, outstanding read owners, sink memory.
    cmd_t          q0[$], q1[$];
    int            tagq[$];
    logic [DW-1:0] resp_q[$], exp0_q[$], exp1_q[$];
    logic [DW-1:0] mem [int];
    int            held = -1;
    int            last = 1;
    int            dut_log[$];
    bit            rst_drv, m_wait_drv, rdv_drv;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : '0;
    endfunction

    // One clock cycle: drive at edge+1, check mid-cycle, advance the model at the next edge.
    task automatic step();
        cmd_t          c0, c1, cw;
        bit            v0, v1, pop, blk, exp_rd, exp_wr, exp_rdv0, exp_rdv1;
        int            win;
        logic [DW-1:0] rdata, old;

        v0 = q0.size() > 0;
        v1 = q1.size() > 0;
        c0 = v0 ? q0[0] : '0;
        c1 = v1 ? q1[0] : '0;
        s0_avn_read = c0.rd; s0_avn_write = c0.wr; s0_avn_address = c0.addr;
        s0_avn_byteenable = c0.be; s0_avn_writedata = c0.wd;
        s1_avn_read = c1.rd; s1_avn_write = c1.wr; s1_avn_address = c1.addr;
        s1_avn_byteenable = c1.be; s1_avn_writedata = c1.wd;
        sys_rst             = rst_drv;
        m_avn_waitrequest   = m_wait_drv;
        m_avn_readdatavalid = rdv_drv;
        m_avn_readdata      = (resp_q.size() > 0) ? resp_q[0] : DW'($urandom);
        #4;

        win = -1; pop = 0; blk = 0; exp_rd = 0; exp_wr = 0; cw = '0;
        if (rst_drv) begin
            check("rst_m_read", m_avn_read, 0);
            check("rst_m_write", m_avn_write, 0);
            check("rst_s0_wait", s0_avn_waitrequest, 1);
            check("rst_s1_wait", s1_avn_waitrequest, 1);
            check("rst_s0_rdv", s0_avn_readdatavalid, 0);
            check("rst_s1_rdv", s1_avn_readdatavalid, 0);
        end else begin
            pop = rdv_drv && tagq.size() > 0;
            if (held >= 0)      win = held;
            else if (v0 && v1)  win = RR ? 1 - last : 0;
            else if (v0)        win = 0;
            else if (v1)        win = 1;
            if (win >= 0) cw = (win == 1) ? c1 : c0;
            blk    = (win >= 0) && cw.rd && tagq.size() == RD_OUTST && !pop;
            exp_rd = (win >= 0) && cw.rd && !blk;
            exp_wr = (win >= 0) && cw.wr;
            check("m_read", m_avn_read, exp_rd);
            check("m_write", m_avn_write, exp_wr);
            if (exp_rd || exp_wr) begin
                check("m_addr", m_avn_address, cw.addr);
                check("m_be", m_avn_byteenable, cw.be);
            end
            if (exp_wr) check("m_wdata", m_avn_writedata, cw.wd);
            if (win == 0) begin
                check("s0_wait_gnt", s0_avn_waitrequest, m_wait_drv | blk);
                if (v1) check("s1_wait_lose", s1_avn_waitrequest, 1);
            end
            if (win == 1) begin
                check("s1_wait_gnt", s1_avn_waitrequest, m_wait_drv | blk);
                if (v0) check("s0_wait_lose", s0_avn_waitrequest, 1);
            end
            exp_rdv0 = pop && tagq[0] == 0;
            exp_rdv1 = pop && tagq[0] == 1;
            check("s0_rdv", s0_avn_readdatavalid, exp_rdv0);
            check("s1_rdv", s1_avn_readdatavalid, exp_rdv1);
            if (exp_rdv0 && exp0_q.size() > 0) begin
                check("s0_rdata", s0_avn_readdata, exp0_q[0]);
                void'(exp0_q.pop_front());
            end
            if (exp_rdv1 && exp1_q.size() > 0) begin
                check("s1_rdata", s1_avn_readdata, exp1_q[0]);
                void'(exp1_q.pop_front());
            end
            if ((m_avn_read || m_avn_write) && !m_avn_waitrequest)
                dut_log.push_back(!s0_avn_waitrequest ? 0 : (!s1_avn_waitrequest ? 1 : 2));
        end

        @(posedge sys_clk);
        if (rst_drv) begin
            tagq.delete(); resp_q.delete(); exp0_q.delete(); exp1_q.delete();
            held = -1;
            last = 1;
        end else begin
            if (pop) void'(tagq.pop_front());
            if (rdv_drv && resp_q.size() > 0) void'(resp_q.pop_front());
            if ((exp_rd || exp_wr) && !m_wait_drv) begin
                if (exp_rd) begin
                    rdata = mem_rd(cw.addr);
                    tagq.push_back(win);
                    resp_q.push_back(rdata);
                    if (win == 0) exp0_q.push_back(rdata);
                    else          exp1_q.push_back(rdata);
                end else begin
                    old = mem_rd(cw.addr);
                    for (int b = 0; b < BW; b++)
                        if (cw.be[b]) old[8*b +: 8] = cw.wd[8*b +: 8];
                    mem[int'(cw.addr)] = old;
                end
                if (win == 0) void'(q0.pop_front());
                else          void'(q1.pop_front());
                last = win;
            end
            held = ((exp_rd || exp_wr) && m_wait_drv) ? win : -1;
        end
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_wait_drv = 0;
        rdv_drv    = 1;
        while ((q0.size() > 0 || q1.size() > 0 || resp_q.size() > 0) && n < 64) begin
            step();
            n++;
        end
        check("drain_bound", q0.size() + q1.size() + resp_q.size(), 0);
        rdv_drv = 0;
    endtask

    function automatic cmd_t mk(input bit rd, input int addr, input int data);
        cmd_t c;
        c.rd   = rd;
        c.wr   = !rd;
        c.addr = AW'(addr);
        c.be   = '1;
        c.wd   = DW'(data);
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c    = mk($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
        c.be = BW'($urandom_range(1, 3));
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_drv = 1; m_wait_drv = 0; rdv_drv = 0;
        @(posedge sys_clk);
        #1;
        repeat (2) step();
        rst_drv = 0;

        // Single uncontended write goes straight through.
        dut_log.delete();
        q0.push_back(mk(0, 'h10, 'hA5A5));
        step();
        check("t_write_acc", dut_log.size(), 1);

        // s0 held under waitrequest; s1 arrives but waits for s0 to be accepted.
        dut_log.delete();
        q0.push_back(mk(0, 'h40, 'h1234));
        m_wait_drv = 1;
        step();
        q1.push_back(mk(1, 'h50, 0));
        repeat (2) step();
        m_wait_drv = 0;
        repeat (2) step();
        check("t_hold_n", dut_log.size(), 2);
        if (dut_log.size() == 2) begin
            check("t_hold_first", dut_log[0], 0);
            check("t_hold_second", dut_log[1], 1);
        end
        drain();

        // Read routing back to the issuing requester in order.
        mem[32'h20] = 16'h1111;
        mem[32'h30] = 16'h2222;
        q1.push_back(mk(1, 'h20, 0));
        step();
        q0.push_back(mk(1, 'h30, 0));
        step();
        drain();

        // Tag FIFO full: fifth read stalls until a response pops a tag.
        dut_log.delete();
        for (int i = 0; i < 5; i++) q1.push_back(mk(1, 'h60 + i, 0));
        repeat (6) step();
        check("t_full_acc4", dut_log.size(), 4);
        rdv_drv = 1;
        step();
        check("t_full_acc5", dut_log.size(), 5);
        drain();

        // Reset with reads outstanding; late responses are dropped.
        q1.push_back(mk(1, 'h70, 0));
        q1.push_back(mk(1, 'h71, 0));
        repeat (2) step();
        rst_drv = 1;
        repeat (2) step();
        rst_drv = 0;
        rdv_drv = 1;
        repeat (2) step();
        rdv_drv = 0;

        // Contention right after reset: both requesters hold four writes each.
        dut_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 'h100 + i, 'hA000 + i));
            q1.push_back(mk(0, 'h200 + i, 'hB000 + i));
        end
        repeat (8) step();
        check("t_contend_n", dut_log.size(), 8);
        if (dut_log.size() == 8)
            for (int i = 0; i < 8; i++)
                check($sformatf("t_contend_gnt%0d", i), dut_log[i], RR ? (i % 2) : (i < 4 ? 0 : 1));
        drain();

        // Randomized traffic with alternating fast and slow response phases.
        for (int i = 0; i < 3000; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_cmd());
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_cmd());
            m_wait_drv = $urandom_range(0, 3) == 0;
            if (((i / 250) % 2) == 1)
                rdv_drv = resp_q.size() > 0 && $urandom_range(0, 7) == 0;
            else
                rdv_drv = resp_q.size() > 0 && $urandom_range(0, 1) == 0;
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
